rng_seven_segment: RTL and testbench

RNG_SEVEN_SEGMENT -- requirements
Module: rng_seven_segment

---
 rtl/rng_seven_segment_pkg.sv | 34 +++
 rtl/rng_seven_segment_scan.sv | 60 ++++++
 rtl/rng_seven_segment.sv | 67 ++++++
 tb/tb_rng_seven_segment.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rng_seven_segment_pkg.sv
// Shared constants for the random-digit generator and its seven-segment scanner.
// RNG_WILDCARD_EN widens the digit range to 0-10, where 10 is the wildcard code.
package rng_seven_segment_pkg;

  localparam logic [31:0] LFSR_TAPS        = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED_XOR = 32'hDEADBEEF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] WILDCARD_CODE = 4'd10;

`ifdef RNG_WILDCARD_EN
  localparam int unsigned DIGIT_MOD = 11;
`else
  localparam int unsigned DIGIT_MOD = 10;
`endif

  // Active-low {g,f,e,d,c,b,a}; entry [n] is the pattern for code n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [3:0] digit_of(input logic [7:0] b);
    return 4'(b % 8'(DIGIT_MOD));
  endfunction

endpackage

// File: rtl/rng_seven_segment_scan.sv
// Four-digit multiplexed seven-segment scanner with registered anode/cathode outputs.
module seg7_scan
  import rng_seven_segment_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blink,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [3:0]    cur_digit;

  always_comb begin
    cur_digit = digit0;
    case (scan_idx)
      2'd0: cur_digit = digit0;
      2'd1: cur_digit = digit1;
      2'd2: cur_digit = digit2;
      2'd3: cur_digit = digit3;
      default: cur_digit = digit0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
    end else begin
      if (refresh_cnt == LAST) begin
        refresh_cnt <= '0;
        scan_idx    <= scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      // Blanking only masks the outputs; the scan position keeps advancing.
      if (blink) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(4'b0001 << scan_idx);
        seg <= SEG_TABLE[cur_digit];
      end
    end
  end

endmodule

// File: rtl/rng_seven_segment.sv
// Galois-LFSR random digit generator driving a multiplexed four-digit display.
// RNG_WILDCARD_EN selects digits 0-10 (10 = wildcard) instead of 0-9.
module rng_seven_segment
  import rng_seven_segment_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter logic [31:0] SEED_XOR       = DEFAULT_SEED_XOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_en,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [3:0] an
);

  logic [31:0] entropy;
  logic [31:0] lfsr;
  logic [31:0] seed_val;
  logic [3:0]  d_q [4];

  assign seed_val = entropy ^ SEED_XOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      entropy <= '0;
      lfsr    <= 32'h1;
      for (int unsigned i = 0; i < 4; i++) d_q[i] <= '0;
    end else begin
      entropy <= entropy + 32'd1;
      // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
      if (seed_en)
        lfsr <= (seed_val == 32'h0) ? 32'h1 : seed_val;
      else
        lfsr <= lfsr_next(lfsr);
      for (int unsigned i = 0; i < 4; i++) d_q[i] <= digit_of(lfsr[8*i +: 8]);
    end
  end

  assign d0 = d_q[0];
  assign d1 = d_q[1];
  assign d2 = d_q[2];
  assign d3 = d_q[3];

  seg7_scan #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .blink (blink),
    .digit0(digit0),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .seg   (seg),
    .an    (an)
  );

endmodule

// File: tb/tb_rng_seven_segment.sv
// Self-checking bench for rng_seven_segment: behavioural model plus directed literal checks.
module tb_rng_seven_segment;

`ifdef RNG_WILDCARD_EN
  localparam int M = 11;
`else
  localparam int M = 10;
`endif
  localparam int R = 4;
  localparam logic [31:0] SX2 = 32'd5;
  localparam logic [6:0] TB_SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic clk = 1'b0;
  logic rst, seed_en, blink;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] d0, d1, d2, d3, e0, e1, e2, e3;
  logic [6:0] seg, seg2;
  logic [3:0] an, an2;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rng_seven_segment #(.REFRESH_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .seed_en(seed_en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blink(blink), .seg(seg), .an(an)
  );

  // Second instance whose SEED_XOR makes a zero-seed reachable within a few cycles.
  rng_seven_segment #(.REFRESH_CYCLES(R), .SEED_XOR(SX2)) dut2 (
    .clk(clk), .rst(rst), .seed_en(seed_en),
    .d0(e0), .d1(e1), .d2(e2), .d3(e3),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blink(blink), .seg(seg2), .an(an2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_lfsr, m_lfsr2, m_cnt;
  int          m_n;
  bit          started = 0;
  logic [3:0]  x_d [4];
  logic [3:0]  x_e [4];
  logic [3:0]  x_an;
  logic [6:0]  x_seg;
  bit          seen [4][16];

  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [3:0] digit_in(input int k);
    case (k)
      0: return digit0;
      1: return digit1;
      2: return digit2;
      default: return digit3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr = 32'h1; m_lfsr2 = 32'h1; m_cnt = 0; m_n = 0;
      for (int i = 0; i < 4; i++) begin x_d[i] = 0; x_e[i] = 0; end
      x_an = 4'hF; x_seg = 7'h7F;
      started = 1;
    end else begin
      int k;
      logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
        x_d[i] = 4'(((m_lfsr >> (8*i)) & 32'hFF) % M);
        x_e[i] = 4'(((m_lfsr2 >> (8*i)) & 32'hFF) % M);
      end
      k = (m_n / R) % 4;
      x_an  = blink ? 4'hF : ~(4'b0001 << k);
      x_seg = blink ? 7'h7F : TB_SEG[digit_in(k)];
      if (seed_en) begin
        v = m_cnt ^ 32'hDEADBEEF; m_lfsr  = (v == 0) ? 32'h1 : v;
        v = m_cnt ^ SX2;          m_lfsr2 = (v == 0) ? 32'h1 : v;
      end else begin
        m_lfsr = step(m_lfsr); m_lfsr2 = step(m_lfsr2);
      end
      m_cnt = m_cnt + 1;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("an", an, x_an);
      chk("seg", seg, x_seg);
      chk("d0", d0, x_d[0]); chk("d1", d1, x_d[1]);
      chk("d2", d2, x_d[2]); chk("d3", d3, x_d[3]);
      chk("dut2_d0", e0, x_e[0]); chk("dut2_d1", e1, x_e[1]);
      chk("dut2_d2", e2, x_e[2]); chk("dut2_d3", e3, x_e[3]);
      seen[0][d0] = 1; seen[1][d1] = 1; seen[2][d2] = 1; seen[3][d3] = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; seed_en = 0; blink = 0;
    digit0 = 4'd0; digit1 = 4'd1; digit2 = 4'd2; digit3 = 4'd3;
    repeat (3) tick();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_d", {d3, d2, d1, d0}, 16'h0);
    rst = 0;

    // Entropy is 5 before the sixth post-reset edge.
    repeat (5) tick();
    seed_en = 1; tick(); seed_en = 0;
    tick();
`ifdef RNG_WILDCARD_EN
    chk("seed_digits", {d3, d2, d1, d0}, 16'h2833);
`else
    chk("seed_digits", {d3, d2, d1, d0}, 16'h2304);
`endif
    chk("zero_seed_digits", {e3, e2, e1, e0}, 16'h0001);
    chk("scan_n7_an", an, 4'b1101);  chk("scan_n7_seg", seg, 7'h79);
    repeat (2) tick();
    chk("scan_n9_an", an, 4'b1011);  chk("scan_n9_seg", seg, 7'h24);
    repeat (4) tick();
    chk("scan_n13_an", an, 4'b0111); chk("scan_n13_seg", seg, 7'h30);
    repeat (4) tick();
    chk("scan_n17_an", an, 4'b1110); chk("scan_n17_seg", seg, 7'h40);

    digit0 = 4'd10; digit1 = 4'd15;
    tick();
    chk("dash_an", an, 4'b1110);     chk("dash_seg", seg, 7'h3F);
    repeat (3) tick();
    chk("blank_an", an, 4'b1101);    chk("blank_seg", seg, 7'h7F);

    tick();
    blink = 1; tick();
    chk("blink_an", an, 4'hF);       chk("blink_seg", seg, 7'h7F);
    repeat (2) tick();
    blink = 0; tick();
    chk("resume_an", an, 4'b1011);   chk("resume_seg", seg, 7'h24);

    digit0 = 4'd0; digit1 = 4'd1;
    for (int c = 0; c < 20000; c++) begin
      if (c % 97 == 0) begin
        digit0 = 4'($urandom_range(0, 15)); digit1 = 4'($urandom_range(0, 15));
        digit2 = 4'($urandom_range(0, 15)); digit3 = 4'($urandom_range(0, 15));
      end
      blink   = (c % 311) < 9;
      seed_en = (c % 1499) == 700;
      rst     = (c == 10000);
      if (c == 10000) seed_en = 1;
      tick();
    end
    rst = 0; seed_en = 0; blink = 0;
    tick();

    for (int i = 0; i < 4; i++)
      for (int v = 0; v < 16; v++)
        chk($sformatf("cover_d%0d_val%0d", i, v), 32'(seen[i][v]), 32'(v < M));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
